// File: rtl/display_pager_if.sv
// Display pager signal bundle: page/blink/blank controls and glyph data in,
// registered segment lanes and displayed page index out.
interface display_pager_if #(
    parameter int NUM_DIGITS = 4,
    parameter int NUM_PAGES  = 4
);
    localparam int PW = $clog2(NUM_PAGES);

    logic [NUM_PAGES-1:0]              page_sel;
    logic                              auto_en;
    logic                              sync_ok;
    logic                              blank_lz;
    logic [NUM_PAGES*NUM_DIGITS*5-1:0] glyph;
    logic [NUM_DIGITS*7-1:0]           hex;
    logic [PW-1:0]                     page;

    modport master (
        output page_sel, auto_en, sync_ok, blank_lz, glyph,
        input  hex, page
    );

    modport slave (
        input  page_sel, auto_en, sync_ok, blank_lz, glyph,
        output hex, page
    );
endinterface

// File: rtl/display_pager.sv
// display_pager: paged seven-segment driver with switch/auto page selection,
// blink while unsynchronised and leading-zero blanking. Outputs are active low.
// Optional build macro DISPLAY_PAGER_SCAN_EN enables multiplexed-panel mode,
// where only one lane (rotating once per tick) carries its pattern.
module display_pager #(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_PAGES   = 4,
    parameter int TICK_DIV    = 50000,
    parameter int DWELL_TICKS = 3000,
    parameter int BLINK_TICKS = 500
) (
    input  logic             clk,
    input  logic             reset_n,
    display_pager_if.slave   bus
);
    localparam int PW  = $clog2(NUM_PAGES);
    localparam int PSW = $clog2(TICK_DIV);
    localparam int DW  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic {PH_OFF = 1'b0, PH_ON = 1'b1} phase_t;

    logic [PSW-1:0]          presc;
    logic                    tick;
    logic [DW-1:0]           dwell;
    logic [BW-1:0]           blink_cnt;
    phase_t                  phase;
    logic [PW-1:0]           sel_idx;
    logic [NUM_DIGITS*7-1:0] hex_next;

`ifdef DISPLAY_PAGER_SCAN_EN
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    logic [SW-1:0] scan_idx;
`endif

    // Active-high GFEDCBA pattern for a 5-bit glyph code.
    function automatic logic [6:0] decode(input logic [4:0] g);
        case (g)
            5'h00: decode = 7'b0111111;
            5'h01: decode = 7'b0000110;
            5'h02: decode = 7'b1011011;
            5'h03: decode = 7'b1001111;
            5'h04: decode = 7'b1100110;
            5'h05: decode = 7'b1101101;
            5'h06: decode = 7'b1111101;
            5'h07: decode = 7'b0000111;
            5'h08: decode = 7'b1111111;
            5'h09: decode = 7'b1101111;
            5'h0A: decode = 7'b1110111;
            5'h0B: decode = 7'b1111100;
            5'h0C: decode = 7'b0111001;
            5'h0D: decode = 7'b1011110;
            5'h0E: decode = 7'b1111001;
            5'h0F: decode = 7'b1110001;
            5'h11: decode = 7'b1000000;
            5'h12: decode = 7'b1011100;
            5'h13: decode = 7'b1111000;
            5'h14: decode = 7'b0011100;
            5'h15: decode = 7'b1110100;
            5'h16: decode = 7'b1010000;
            5'h17: decode = 7'b1010100;
            5'h18: decode = 7'b1110011;
            5'h19: decode = 7'b0111000;
            default: decode = 7'b0000000;
        endcase
    endfunction

    // Tick is a one-cycle pulse on the cycle the prescaler wraps.
    assign tick = (presc == PSW'(TICK_DIV - 1));

    // Lowest set page_sel bit wins.
    always_comb begin
        sel_idx = '0;
        for (int unsigned i = NUM_PAGES; i > 0; i--) begin
            if (bus.page_sel[i-1]) sel_idx = PW'(i - 1);
        end
    end

    // Next segment image: blanking scan from the top digit, decode, scan mask, blink.
    always_comb begin
        logic       seen_nz;
        logic [4:0] g;
        logic       lane_en;
        int unsigned d;
        hex_next = '1;
        seen_nz  = 1'b0;
        g        = '0;
        lane_en  = 1'b1;
        d        = 0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            d = NUM_DIGITS - 1 - k;
            g = bus.glyph[(int'(bus.page) * NUM_DIGITS + int'(d)) * 5 +: 5];
            if (g != 5'h00) begin
                seen_nz = 1'b1;
            end else if (bus.blank_lz && !seen_nz && d != 0) begin
                g = 5'h10;
            end
`ifdef DISPLAY_PAGER_SCAN_EN
            lane_en = (32'(scan_idx) == d);
`else
            lane_en = 1'b1;
`endif
            // sync_ok bypasses the phase register so a rise restores the display next edge.
            if (lane_en && (bus.sync_ok || phase == PH_ON))
                hex_next[d*7 +: 7] = ~decode(g);
        end
    end

    // Tick prescaler.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // Page register and dwell counter; page_sel overrides any same-cycle tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.page <= '0;
            dwell    <= '0;
        end else if (bus.page_sel != '0) begin
            bus.page <= sel_idx;
            dwell    <= '0;
        end else if (bus.auto_en) begin
            if (tick) begin
                if (dwell == DW'(DWELL_TICKS - 1)) begin
                    dwell    <= '0;
                    bus.page <= (bus.page == PW'(NUM_PAGES - 1)) ? '0 : bus.page + 1'b1;
                end else begin
                    dwell <= dwell + 1'b1;
                end
            end
        end else begin
            dwell <= '0;
        end
    end

    // Blink phase: forced on while synchronised, toggles every BLINK_TICKS ticks otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= PH_ON;
            blink_cnt <= '0;
        end else if (bus.sync_ok) begin
            phase     <= PH_ON;
            blink_cnt <= '0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

`ifdef DISPLAY_PAGER_SCAN_EN
    // Scan lane index advances once per tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  scan_idx <= '0;
        else if (tick) scan_idx <= (scan_idx == SW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end
`endif

    // Registered segment outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.hex <= '1;
        else          bus.hex <= hex_next;
    end
endmodule

// File: tb/tb_display_pager.sv
// Directed self-checking bench for display_pager (4 digits, 4 pages, fast ticks).
module tb_display_pager;
    localparam int ND = 4;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    display_pager_if #(.NUM_DIGITS(ND), .NUM_PAGES(NP)) bus ();

    display_pager #(
        .NUM_DIGITS(ND), .NUM_PAGES(NP), .TICK_DIV(4),
        .DWELL_TICKS(3), .BLINK_TICKS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    localparam logic [27:0] ALL1 = 28'hFFFFFFF;
    // Expected images {digit3, digit2, digit1, digit0}, active low.
    localparam logic [27:0] P0 = {7'h79, 7'h24, 7'h30, 7'h19};  // 1 2 3 4
    localparam logic [27:0] P1 = {7'h12, 7'h02, 7'h78, 7'h00};  // 5 6 7 8
    localparam logic [27:0] P2 = {7'h10, 7'h08, 7'h03, 7'h46};  // 9 A b C
    localparam logic [27:0] P3 = {7'h21, 7'h06, 7'h0E, 7'h40};  // d E F 0

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_page(input int p, input logic [4:0] g3, g2, g1, g0);
        bus.glyph[(p*ND+3)*5 +: 5] = g3;
        bus.glyph[(p*ND+2)*5 +: 5] = g2;
        bus.glyph[(p*ND+1)*5 +: 5] = g1;
        bus.glyph[(p*ND+0)*5 +: 5] = g0;
    endtask

    task automatic test_reset;
        logic [27:0] exp;
        reset_n = 1'b0;
        bus.page_sel = '0; bus.auto_en = 1'b0; bus.sync_ok = 1'b1; bus.blank_lz = 1'b0;
        bus.glyph = '0;
        set_page(0, 5'h1, 5'h2, 5'h3, 5'h4);
        set_page(1, 5'h5, 5'h6, 5'h7, 5'h8);
        set_page(2, 5'h9, 5'hA, 5'hB, 5'hC);
        set_page(3, 5'hD, 5'hE, 5'hF, 5'h0);
        step(3);
        checks++;
        if (bus.hex !== ALL1) begin
            errors++; $display("FAIL reset_hex: got %h expected %h", bus.hex, ALL1);
        end
        checks++;
        if (bus.page !== 2'd0) begin
            errors++; $display("FAIL reset_page: got %0d expected 0", bus.page);
        end
        reset_n = 1'b1;
        step(1);
`ifdef DISPLAY_PAGER_SCAN_EN
        exp = {7'h7F, 7'h7F, 7'h7F, 7'h19};
`else
        exp = P0;
`endif
        checks++;
        if (bus.hex !== exp) begin
            errors++; $display("FAIL reset_release_hex: got %h expected %h", bus.hex, exp);
        end
    endtask

    task automatic test_page_sel;
        bus.page_sel = 4'b0110;
        step(1);
        checks++;
        if (bus.page !== 2'd1) begin
            errors++; $display("FAIL sel_page_1edge: got %0d expected 1", bus.page);
        end
        checks++;
        if (bus.hex !== P0) begin
            errors++; $display("FAIL sel_hex_1edge: got %h expected %h", bus.hex, P0);
        end
        step(1);
        checks++;
        if (bus.hex !== P1) begin
            errors++; $display("FAIL sel_hex_2edge: got %h expected %h", bus.hex, P1);
        end
        bus.page_sel = '0; bus.auto_en = 1'b0;
        step(30);
        checks++;
        if (bus.page !== 2'd1 || bus.hex !== P1) begin
            errors++; $display("FAIL sel_hold: got page %0d hex %h expected page 1 hex %h", bus.page, bus.hex, P1);
        end
        bus.page_sel = 4'b1000;
        step(2);
        checks++;
        if (bus.page !== 2'd3 || bus.hex !== P3) begin
            errors++; $display("FAIL sel_page3: got page %0d hex %h expected page 3 hex %h", bus.page, bus.hex, P3);
        end
    endtask

    task automatic test_auto_rotate;
        logic [1:0] prev;
        logic [1:0] exp_pg;
        int n;
        bus.page_sel = 4'b0001; bus.auto_en = 1'b1;
        step(5);
        bus.page_sel = '0;
        prev = 2'd0;
        for (int k = 0; k < 4; k++) begin
            exp_pg = 2'(k + 1);
            n = 0;
            while (bus.page === prev && n < 20) begin
                step(1);
                n++;
            end
            checks++;
            if (bus.page !== exp_pg) begin
                errors++; $display("FAIL auto_page_%0d: got %0d expected %0d after %0d cycles", k, bus.page, exp_pg, n);
            end
            checks++;
            if (k == 0) begin
                if (n < 9 || n > 12) begin
                    errors++; $display("FAIL auto_first_dwell: got %0d cycles expected 9..12", n);
                end
            end else if (n != 12) begin
                errors++; $display("FAIL auto_interval_%0d: got %0d cycles expected 12", k, n);
            end
            prev = bus.page;
        end
        bus.auto_en = 1'b0;
        step(30);
        checks++;
        if (bus.page !== 2'd0) begin
            errors++; $display("FAIL auto_off_hold: got %0d expected 0", bus.page);
        end
    endtask

    task automatic test_blink;
        int n;
        bus.page_sel = 4'b0001; bus.auto_en = 1'b0;
        step(2);
        bus.sync_ok = 1'b0;
        n = 0;
        while (bus.hex !== ALL1 && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (bus.hex !== ALL1) begin
            errors++; $display("FAIL blink_goes_off: got %h expected %h", bus.hex, ALL1);
        end
        n = 0;
        while (bus.hex === ALL1 && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (n != 8 || bus.hex !== P0) begin
            errors++; $display("FAIL blink_off_run: got %0d cycles then %h expected 8 then %h", n, bus.hex, P0);
        end
        n = 0;
        while (bus.hex === P0 && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (n != 8 || bus.hex !== ALL1) begin
            errors++; $display("FAIL blink_on_run: got %0d cycles then %h expected 8 then %h", n, bus.hex, ALL1);
        end
        step(3);
        checks++;
        if (bus.hex !== ALL1) begin
            errors++; $display("FAIL blink_mid_off: got %h expected %h", bus.hex, ALL1);
        end
        bus.sync_ok = 1'b1;
        step(1);
        checks++;
        if (bus.hex !== P0) begin
            errors++; $display("FAIL blink_sync_restore: got %h expected %h", bus.hex, P0);
        end
    endtask

    task automatic test_blanking;
        logic [27:0] exp;
        bus.page_sel = 4'b0100; bus.blank_lz = 1'b1;
        set_page(2, 5'h0, 5'h0, 5'h0, 5'h7);
        step(2);
        exp = {7'h7F, 7'h7F, 7'h7F, 7'h78};
        checks++;
        if (bus.hex !== exp) begin
            errors++; $display("FAIL lz_0007: got %h expected %h", bus.hex, exp);
        end
        set_page(2, 5'h0, 5'h0, 5'h0, 5'h0);
        step(1);
        exp = {7'h7F, 7'h7F, 7'h7F, 7'h40};
        checks++;
        if (bus.hex !== exp) begin
            errors++; $display("FAIL lz_0000: got %h expected %h", bus.hex, exp);
        end
        set_page(2, 5'h0, 5'h5, 5'h0, 5'h0);
        step(1);
        exp = {7'h7F, 7'h12, 7'h40, 7'h40};
        checks++;
        if (bus.hex !== exp) begin
            errors++; $display("FAIL lz_0500: got %h expected %h", bus.hex, exp);
        end
        bus.blank_lz = 1'b0;
        step(1);
        exp = {7'h40, 7'h12, 7'h40, 7'h40};
        checks++;
        if (bus.hex !== exp) begin
            errors++; $display("FAIL lz_disabled: got %h expected %h", bus.hex, exp);
        end
    endtask

    task automatic test_special_glyphs;
        logic [27:0] exp;
        bus.page_sel = 4'b1000;
        set_page(3, 5'h11, 5'h18, 5'h19, 5'h1A);
        step(2);
        exp = {7'h3F, 7'h0C, 7'h47, 7'h7F};
        checks++;
        if (bus.hex !== exp) begin
            errors++; $display("FAIL glyph_dash_P_L_blank: got %h expected %h", bus.hex, exp);
        end
        set_page(3, 5'h12, 5'h13, 5'h14, 5'h15);
        step(1);
        // o t u h
        exp = {7'h23, 7'h07, 7'h63, 7'h0B};
        checks++;
        if (bus.hex !== exp) begin
            errors++; $display("FAIL glyph_o_t_u_h: got %h expected %h", bus.hex, exp);
        end
        set_page(3, 5'h16, 5'h17, 5'h10, 5'h1F);
        step(1);
        // r n blank blank
        exp = {7'h2F, 7'h2B, 7'h7F, 7'h7F};
        checks++;
        if (bus.hex !== exp) begin
            errors++; $display("FAIL glyph_r_n_blanks: got %h expected %h", bus.hex, exp);
        end
        bus.page_sel = 4'b0100;
        set_page(2, 5'h9, 5'hA, 5'hB, 5'hC);
        step(2);
        checks++;
        if (bus.hex !== P2) begin
            errors++; $display("FAIL glyph_page2: got %h expected %h", bus.hex, P2);
        end
    endtask

`ifdef DISPLAY_PAGER_SCAN_EN
    task automatic test_scan;
        int lane, prev, lit, changes, run;
        bus.page_sel = 4'b0001; bus.sync_ok = 1'b1; bus.blank_lz = 1'b0;
        step(2);
        prev = -1; changes = 0; run = 0;
        for (int c = 0; c < 32; c++) begin
            lit = 0; lane = -1;
            for (int d = 0; d < ND; d++) begin
                if (bus.hex[d*7 +: 7] !== 7'h7F) begin
                    lit++; lane = d;
                end
            end
            checks++;
            if (lit != 1 || bus.hex[lane*7 +: 7] !== P0[lane*7 +: 7]) begin
                errors++; $display("FAIL scan_one_lane: cycle %0d got %0d lit lanes hex %h", c, lit, bus.hex);
            end
            if (prev >= 0 && lane != prev) begin
                changes++;
                checks++;
                if (lane != (prev + 1) % ND || (changes > 1 && run != 4)) begin
                    errors++; $display("FAIL scan_advance: got lane %0d after %0d run %0d expected lane %0d run 4", lane, prev, run, (prev + 1) % ND);
                end
                run = 0;
            end
            run++;
            prev = lane;
            step(1);
        end
        checks++;
        if (changes < 7) begin
            errors++; $display("FAIL scan_changes: got %0d expected at least 7", changes);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef DISPLAY_PAGER_SCAN_EN
        test_scan();
`else
        test_page_sel();
        test_auto_rotate();
        test_blink();
        test_blanking();
        test_special_glyphs();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
